seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 38 +++
 rtl/seq_det_cnt.sv | 23 ++
 rtl/seq_detect_param.sv | 88 ++++++++
 tb/tb_seq_detect_param.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Everything in this package is evaluated at elaboration time, so it creates no logic.
package seq_det_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  // Width needed to hold a state index in 0..len-1.
  function automatic int state_w(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

  // Length of the longest proper prefix of the pattern that is a suffix of
  // (first s pattern bits) followed by b. The pattern is MSB-first in pat[len-1:0].
  function automatic int fallback(input logic [PAT_LEN_MAX-1:0] pat,
                                  input int len, input int s, input logic b);
    int   n;
    int   kmax;
    int   m;
    int   res;
    logic ok;
    logic sym;
    n    = s + 1;
    kmax = (n < len) ? n : len - 1;
    res  = 0;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        m   = n - k + j;
        sym = (m < s) ? pat[len-1-m] : b;
        if (sym != pat[len-1-j]) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_cnt.sv
// Saturating match counter; stops at all-ones and holds until reset.
module seq_det_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised Mealy sequence detector with selectable overlapping/non-overlapping mode.
// Optional saturating match counter (port match_cnt) is built when SEQ_DET_COUNT_EN is defined.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             overlap,
  output logic             y
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int                     SW      = state_w(PAT_LEN);
  localparam logic [PAT_LEN_MAX-1:0] PAT_EXT = PAT_LEN_MAX'(PATTERN);
  localparam int                     BORDER  = fallback(PAT_EXT, PAT_LEN, PAT_LEN - 1, PATTERN[0]);
  localparam logic [SW-1:0]          S_LAST  = SW'(PAT_LEN - 1);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detect_param: PAT_LEN %0d outside %0d..%0d", PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX);
  end

  logic [SW-1:0]      r_s;
  logic [SW-1:0]      w_s_nxt;
  logic               w_y;
  logic [PAT_LEN-1:0] w_exp;
  logic [SW-1:0]      w_fb [PAT_LEN];

  // Per-state expected bit and mismatch fallback, all resolved at elaboration.
  for (genvar g = 0; g < PAT_LEN; g++) begin : g_tab
    localparam int FB = fallback(PAT_EXT, PAT_LEN, g, ~PATTERN[PAT_LEN-1-g]);
    assign w_exp[g] = PATTERN[PAT_LEN-1-g];
    assign w_fb[g]  = SW'(FB);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_y     = 1'b0;
    w_s_nxt = r_s;
    if (en && !rst) begin
      if (i == w_exp[r_s]) begin
        if (r_s == S_LAST) begin
          w_y     = 1'b1;
          w_s_nxt = overlap ? SW'(BORDER) : '0;
        end else begin
          w_s_nxt = r_s + 1'b1;
        end
      end else begin
        w_s_nxt = w_fb[r_s];
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
    end else begin
      r_s <= w_s_nxt;
    end
  end

  assign y = w_y;

`ifdef SEQ_DET_COUNT_EN
  seq_det_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_y),
    .o_cnt (match_cnt)
  );
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three instances (default, 6-bit pattern, 2-bit counter).
// Counter checks are compiled in only when SEQ_DET_COUNT_EN is defined.
module tb_seq_detect_param;

  typedef struct {
    logic  exp;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i   = 1'b0;
  logic ov  = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic y_a, y_b, y_c;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [1:0] cnt_c;
`endif

  int n_checks = 0;
  int n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;

  seq_detect_param u_a (
    .clk(clk), .rst(rst), .en(en_a), .i(i), .overlap(ov), .y(y_a)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  seq_detect_param #(.PAT_LEN(6), .PATTERN(6'b110110)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .i(i), .overlap(ov), .y(y_b)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  seq_detect_param #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .i(i), .overlap(ov), .y(y_c)
`ifdef SEQ_DET_COUNT_EN
    , .match_cnt(cnt_c)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle for instance sel (0=a,1=b,2=c) and queue its expected y.
  task automatic drive(input int sel, input logic e, input logic b, input logic o,
                       input logic r, input logic exp, input string tag);
    exp_t ent;
    @(posedge clk);
    #1;
    en_a = (sel == 0) && e;
    en_b = (sel == 1) && e;
    en_c = (sel == 2) && e;
    i    = b;
    ov   = o;
    rst  = r;
    ent.exp = exp;
    ent.tag = tag;
    case (sel)
      0:       qa.push_back(ent);
      1:       qb.push_back(ent);
      default: qc.push_back(ent);
    endcase
  endtask

  task automatic do_reset(input int sel, input string tag);
    drive(sel, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_rst"});
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_post_rst"});
  endtask

  // bits/exps are MSB-first, n entries long.
  task automatic stream(input int sel, input logic o, input int n,
                        input logic [31:0] bits, input logic [31:0] exps, input string tag);
    for (int k = 0; k < n; k++)
      drive(sel, 1'b1, bits[n-1-k], o, 1'b0, exps[n-1-k], $sformatf("%s_bit%0d", tag, k + 1));
  endtask

  // Monitor: y is valid every cycle an entry is queued; sample on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin e = qa.pop_front(); check(e.tag, 32'(y_a), 32'(e.exp)); end
      if (qb.size() > 0) begin e = qb.pop_front(); check(e.tag, 32'(y_b), 32'(e.exp)); end
      if (qc.size() > 0) begin e = qc.pop_front(); check(e.tag, 32'(y_c), 32'(e.exp)); end
    end
  end

  initial begin
    do_reset(0, "a_init");
`ifdef SEQ_DET_COUNT_EN
    check("a_cnt_reset", 32'(cnt_a), 32'd0);
`endif
    // Default pattern, non-overlapping: matches on bits 5 and 13.
    stream(0, 1'b0, 15, 32'b110101011101010, 32'b000010000000100, "a_novl");
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_novl_idle");
`ifdef SEQ_DET_COUNT_EN
    check("a_novl_cnt", 32'(cnt_a), 32'd2);
`endif
    // Same stream overlapping: matches on bits 5, 7, 13, 15.
    do_reset(0, "a_ovl");
    stream(0, 1'b1, 15, 32'b110101011101010, 32'b000010100000101, "a_ovl");
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_ovl_idle");
`ifdef SEQ_DET_COUNT_EN
    check("a_ovl_cnt", 32'(cnt_a), 32'd4);
`endif
    // en gating: state held across a 3-cycle gap with i=0.
    do_reset(0, "a_en");
    stream(0, 1'b0, 3, 32'b101, 32'b000, "a_en_pre");
    for (int k = 0; k < 3; k++)
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("a_en_gap%0d", k));
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "a_en_resume");
    // Reset mid-match: y suppressed, prefix discarded.
    do_reset(0, "a_midrst");
    stream(0, 1'b0, 3, 32'b101, 32'b000, "a_midrst_pre");
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "a_midrst_rst_cycle");
    stream(0, 1'b0, 5, 32'b01010, 32'b00001, "a_midrst_post");
    // 6-bit pattern 110110, overlapping then non-overlapping.
    do_reset(1, "b_ovl");
    stream(1, 1'b1, 9, 32'b110110110, 32'b000001001, "b_ovl");
    do_reset(1, "b_novl");
    stream(1, 1'b0, 9, 32'b110110110, 32'b000001000, "b_novl");
    // Saturation with a 2-bit counter: five matches.
    do_reset(2, "c_sat");
`ifdef SEQ_DET_COUNT_EN
    check("c_cnt_reset", 32'(cnt_c), 32'd0);
`endif
    stream(2, 1'b0, 20, 32'b10101010101010101010, 32'b00010001000100010001, "c_sat");
    drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "c_sat_idle0");
`ifdef SEQ_DET_COUNT_EN
    check("c_cnt_sat", 32'(cnt_c), 32'd3);
`endif
    drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "c_sat_idle1");
    drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "c_sat_idle2");
`ifdef SEQ_DET_COUNT_EN
    check("c_cnt_held", 32'(cnt_c), 32'd3);
`endif
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
